// File: rtl/sprite_compositor_if.sv
// Pixel, sprite and colour signals shared between the display driver and sprite_compositor.
// master drives coordinates/sprite state; slave (the compositor) returns the registered pixel colour.
interface sprite_compositor_if #(
  parameter int N_PLAYERS = 2,
  parameter int COORD_W   = 10
);
  logic                           frame_start;
  logic                           pix_valid;
  logic [COORD_W-1:0]             DrawX;
  logic [COORD_W-1:0]             DrawY;
  logic [N_PLAYERS*COORD_W-1:0]   PlayerX;
  logic [N_PLAYERS*COORD_W-1:0]   PlayerY;
  logic [COORD_W-1:0]             Player_size;
  logic [N_PLAYERS*COORD_W-1:0]   BulletX;
  logic [N_PLAYERS*COORD_W-1:0]   BulletY;
  logic [COORD_W-1:0]             Bullet_size;
  logic [N_PLAYERS-1:0]           bullet_on;
  logic [N_PLAYERS-1:0]           hit;
  logic [N_PLAYERS*24-1:0]        Player_rgb;
  logic [7:0]                     Red;
  logic [7:0]                     Green;
  logic [7:0]                     Blue;
  logic                           rgb_valid;
  logic [N_PLAYERS-1:0]           flashing;

  modport master (
    output frame_start, pix_valid, DrawX, DrawY, PlayerX, PlayerY, Player_size,
           BulletX, BulletY, Bullet_size, bullet_on, hit, Player_rgb,
    input  Red, Green, Blue, rgb_valid, flashing
  );

  modport slave (
    input  frame_start, pix_valid, DrawX, DrawY, PlayerX, PlayerY, Player_size,
           BulletX, BulletY, Bullet_size, bullet_on, hit, Player_rgb,
    output Red, Green, Blue, rgb_valid, flashing
  );
endinterface

// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor: stage 1 registers per-player square/bullet hits, stage 2 resolves
// priority and hit-flash colour into registered RGB. Per-player flash counters tick on frame_start.
module sprite_compositor #(
  parameter int          N_PLAYERS    = 2,
  parameter int          COORD_W      = 10,
  parameter logic [23:0] BG_RGB       = 24'h00007F,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  sprite_compositor_if.slave bus
);

  localparam int DW = COORD_W + 1;
  localparam int SW = 2 * COORD_W + 2;

  logic [N_PLAYERS-1:0] sq_d, sq_q;
  logic [N_PLAYERS-1:0] bc_d, bc_q;
  logic                 v1_q;
  logic [7:0]           flash_d [N_PLAYERS];
  logic [7:0]           flash_q [N_PLAYERS];
  logic [N_PLAYERS-1:0] flashing_d, flashing_q;
  logic [23:0]          win_rgb;
  logic [23:0]          rgb_d, rgb_q;
  logic                 rgb_valid_q;

  logic [DW-1:0]        pdx, pdy, bdx, bdy;
  logic [SW-1:0]        bd2, br2;
  logic                 found;

  // Signed difference then magnitude, so coordinates near 0 never wrap into a hit.
  function automatic logic [DW-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                             input logic [COORD_W-1:0] b);
    logic signed [DW-1:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return d[DW-1] ? $unsigned(-d) : $unsigned(d);
  endfunction

  always_comb begin
    sq_d = '0;
    bc_d = '0;
    pdx  = '0;
    pdy  = '0;
    bdx  = '0;
    bdy  = '0;
    bd2  = '0;
    br2  = SW'(bus.Bullet_size) * SW'(bus.Bullet_size);
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      pdx     = abs_diff(bus.DrawX, bus.PlayerX[i*COORD_W +: COORD_W]);
      pdy     = abs_diff(bus.DrawY, bus.PlayerY[i*COORD_W +: COORD_W]);
      sq_d[i] = (pdx <= DW'(bus.Player_size)) && (pdy <= DW'(bus.Player_size));
      bdx     = abs_diff(bus.DrawX, bus.BulletX[i*COORD_W +: COORD_W]);
      bdy     = abs_diff(bus.DrawY, bus.BulletY[i*COORD_W +: COORD_W]);
      bd2     = SW'(bdx) * SW'(bdx) + SW'(bdy) * SW'(bdy);
      bc_d[i] = bus.bullet_on[i] && (bd2 <= br2);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      flash_d[i] = flash_q[i];
      if (bus.hit[i]) begin
        flash_d[i] = 8'(FLASH_FRAMES);
      end else if (bus.frame_start && (flash_q[i] != '0)) begin
        flash_d[i] = flash_q[i] - 8'd1;
      end
      flashing_d[i] = (flash_d[i] != '0);
    end
  end

  // Lowest index wins; within an index the player square beats its own bullet.
  always_comb begin
    win_rgb = BG_RGB;
    found   = 1'b0;
    for (int unsigned i = 0; i < N_PLAYERS; i++) begin
      if (!found && sq_q[i]) begin
        found   = 1'b1;
        win_rgb = flash_q[i][0] ? 24'hFFFFFF : bus.Player_rgb[i*24 +: 24];
      end else if (!found && bc_q[i]) begin
        found   = 1'b1;
        win_rgb = bus.Player_rgb[i*24 +: 24];
      end
    end
    rgb_d = v1_q ? win_rgb : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sq_q        <= '0;
      bc_q        <= '0;
      v1_q        <= 1'b0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      flashing_q  <= '0;
      for (int unsigned i = 0; i < N_PLAYERS; i++) begin
        flash_q[i] <= '0;
      end
    end else begin
      sq_q        <= sq_d;
      bc_q        <= bc_d;
      v1_q        <= bus.pix_valid;
      rgb_q       <= rgb_d;
      rgb_valid_q <= v1_q;
      flashing_q  <= flashing_d;
      for (int unsigned i = 0; i < N_PLAYERS; i++) begin
        flash_q[i] <= flash_d[i];
      end
    end
  end

  assign bus.Red       = rgb_q[23:16];
  assign bus.Green     = rgb_q[15:8];
  assign bus.Blue      = rgb_q[7:0];
  assign bus.rgb_valid = rgb_valid_q;
  assign bus.flashing  = flashing_q;

endmodule
